aes_key_expand: RTL



---
 rtl/aes_pkg.sv | 44 ++++
 rtl/sub_table.sv | 35 +++
 rtl/aes_key_expand.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants, state encoding and GF(2^8) helpers for the
//                AES-128 key-schedule engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Number of round keys after round 0 (AES-128).
    localparam int unsigned AES_NUM_ROUNDS = 10;

    // First round constant.
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    // Key-schedule controller states. SUB is only reachable in serial mode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SUB  = 2'd2
    } aes_state_t;

    // Multiply by x in GF(2^8) with the AES reduction polynomial; this is what
    // produces the 80 -> 1b wrap of the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One key-schedule step: key words are w0 = key[127:96] .. w3 = key[31:0],
    // subword is SubWord(RotWord(w3)).
    function automatic logic [127:0] next_round_key(input logic [127:0] key,
                                                    input logic [31:0]  subword,
                                                    input logic [7:0]   rcon);
        logic [31:0] temp, n0, n1, n2, n3;
        temp = subword ^ {rcon, 24'h000000};
        n0   = key[127:96] ^ temp;
        n1   = key[95:64]  ^ n0;
        n2   = key[63:32]  ^ n1;
        n3   = key[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_table.sv
`default_nettype none
// ============================================================================
//  Module      : sub_table
//  Description : AES forward S-box, purely combinational byte lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_table (
    input  logic [7:0] i_addr,
    output logic [7:0] o_data
);

    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Straight table lookup.
    assign o_data = c_SBOX[i_addr];

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand
//  Description : Iterative AES-128 key schedule. Expands a cipher key into
//                round keys 0..10, delivered one at a time over valid/ready.
//                Build option AES_KEY_EXPAND_SERIAL_SBOX_EN selects a single
//                shared S-box (4 substitution cycles per round key) instead of
//                four parallel S-boxes (one round key per cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy
);

    import aes_pkg::*;

    aes_state_t     r_state;
    logic [127:0]   r_key;
    logic [3:0]     r_idx;
    logic [7:0]     r_rcon;
    logic           r_valid;
    logic           r_busy;

    logic           w_hs;
    logic           w_last;
    logic [31:0]    w_rot;

    assign w_hs   = r_valid & rk_ready;
    assign w_last = (r_idx == 4'(AES_NUM_ROUNDS));
    // RotWord of w3: the left-rotated last word of the held key.
    assign w_rot  = {r_key[23:0], r_key[31:24]};

`ifdef AES_KEY_EXPAND_SERIAL_SBOX_EN
    logic [1:0]     r_cnt;
    // Only three substituted bytes are stored; the fourth goes straight from
    // the S-box into the key update on the last SUB cycle.
    logic [23:0]    r_temp;
    logic [7:0]     w_sub_in;
    logic [7:0]     w_sub_out;

    // Byte 0 is the MSB of the rotated word, byte 3 the LSB.
    always_comb begin
        w_sub_in = w_rot[31:24];
        case (r_cnt)
            2'd0:    w_sub_in = w_rot[31:24];
            2'd1:    w_sub_in = w_rot[23:16];
            2'd2:    w_sub_in = w_rot[15:8];
            default: w_sub_in = w_rot[7:0];
        endcase
    end

    sub_table u_sub_table (
        .i_addr (w_sub_in),
        .o_data (w_sub_out)
    );
`else
    logic [31:0]    w_subword;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sub_table u_sub (
                .i_addr (w_rot[8*gi +: 8]),
                .o_data (w_subword[8*gi +: 8])
            );
        end
    endgenerate
`endif

    // Controller: load key on start, hold each round key until accepted,
    // then advance the schedule (directly, or through the SUB byte loop).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_rcon  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef AES_KEY_EXPAND_SERIAL_SBOX_EN
            r_cnt   <= '0;
            r_temp  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_idx   <= '0;
                        r_rcon  <= AES_RCON_INIT;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
`ifdef AES_KEY_EXPAND_SERIAL_SBOX_EN
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= SUB;
`else
                            r_key   <= next_round_key(r_key, w_subword, r_rcon);
                            r_idx   <= r_idx + 4'd1;
                            r_rcon  <= xtime(r_rcon);
`endif
                        end
                    end
                end
`ifdef AES_KEY_EXPAND_SERIAL_SBOX_EN
                SUB: begin
                    r_temp <= {r_temp[15:0], w_sub_out};
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_key   <= next_round_key(r_key, {r_temp, w_sub_out}, r_rcon);
                        r_idx   <= r_idx + 4'd1;
                        r_rcon  <= xtime(r_rcon);
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rk_valid = r_valid;
    assign rk_out   = r_key;
    assign rk_idx   = r_idx;
    assign busy     = r_busy;

endmodule
`default_nettype wire
